uart_tx_arbiter: RTL and testbench

Shares the single transmit port of UART_top (datain_ext/new_in) among four byte requesters with round-robin arbitration. UART_top exposes no transmit-busy flag, so the arbiter paces frames with an internal guard counter of FRAME_CYCLES clocks after every new_in pulse. It sits between system producers (command/status/debug sources) and UART_top.

---
 rtl/uart_tx_arbiter.sv | 115 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_top transmit port among four byte sources.
// Frames are paced by a guard counter because UART_top exposes no busy flag.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 8,
  parameter int FRAME_CYCLES = 52083,
  parameter int CNT_W        = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]       datain_ext,
  output logic                    new_in,
  output logic                    busy,
  output logic [1:0]              last_grant
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               new_in_q, new_in_d;
  logic               busy_q, busy_d;
  logic [1:0]         last_q, last_d;

  logic               pick_vld;
  logic [1:0]         pick_idx;
  logic [1:0]         cand;

  // Scan from farthest to nearest so the nearest index after last_q wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = last_q;
    cand     = last_q;
    for (int k = 4; k >= 1; k--) begin
      cand = last_q + 2'(k);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = '0;
    data_d   = data_q;
    new_in_d = 1'b0;
    last_d   = last_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d[pick_idx] = 1'b1;
          data_d  = req_data[pick_idx*DATA_W +: DATA_W];
          last_d  = pick_idx;
          state_d = SEND;
        end
      end
      SEND: begin
        new_in_d = 1'b1;
        cnt_d    = CNT_LOAD;
        state_d  = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gnt_q    <= '0;
      data_q   <= '0;
      new_in_q <= 1'b0;
      busy_q   <= 1'b0;
      last_q   <= 2'd3;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      data_q   <= data_d;
      new_in_q <= new_in_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
    end
  end

  assign gnt        = gnt_q;
  assign datain_ext = data_q;
  assign new_in     = new_in_q;
  assign busy       = busy_q;
  assign last_grant = last_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a short guard frame.
// Expected values are hand-derived from the grant/frame timing.
module tb_uart_tx_arbiter;

  localparam int F = 8;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [7:0]  datain_ext;
  logic        new_in;
  logic        busy;
  logic [1:0]  last_grant;

  int n_chk;
  int n_err;

  uart_tx_arbiter #(
    .N_REQ(4),
    .DATA_W(8),
    .FRAME_CYCLES(F),
    .CNT_W(20)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .gnt(gnt),
    .datain_ext(datain_ext),
    .new_in(new_in),
    .busy(busy),
    .last_grant(last_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_gnt(input string tag);
    int n;
    n = 0;
    tick();
    while (gnt == 4'd0 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 32'(gnt != 4'd0), 32'd1);
  endtask

  initial begin
    int bc;
    int np;
    int k;
    int g;
    int last_c;
    int ng;
    logic [7:0] exp_b [5];

    n_chk    = 0;
    n_err    = 0;
    rst      = 1'b1;
    req      = 4'd0;
    req_data = 32'h0;
    tick();
    tick();
    tick();
    rst = 1'b0;

    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_data", 32'(datain_ext), 32'd0);
    chk("rst_new_in", 32'(new_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_last", 32'(last_grant), 32'd3);

    // single request, data change during WAIT
    req      = 4'b0001;
    req_data = 32'h0000_001F;
    tick();
    chk("t1_gnt", 32'(gnt), 32'b0001);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_last", 32'(last_grant), 32'd0);
    req = 4'b0000;
    tick();
    chk("t1_new_in", 32'(new_in), 32'd1);
    chk("t1_data", 32'(datain_ext), 32'h1F);
    chk("t1_gnt_off", 32'(gnt), 32'd0);
    req_data = 32'h0000_0055;
    bc = 2;
    np = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!busy) break;
      bc++;
      if (new_in) np++;
    end
    chk("t1_busy_len", 32'(bc), 32'(F + 1));
    chk("t1_extra_new_in", 32'(np), 32'd0);
    chk("t1_data_hold", 32'(datain_ext), 32'h1F);
    chk("t1_idle", 32'(busy), 32'd0);

    // all four held: round robin from 0
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    req_data = 32'hA3A2_A1A0;
    req      = 4'b1111;
    exp_b[0] = 8'hA0;
    exp_b[1] = 8'hA1;
    exp_b[2] = 8'hA2;
    exp_b[3] = 8'hA3;
    exp_b[4] = 8'hA0;
    k = 0;
    g = 0;
    last_c = 0;
    for (int c = 0; c < 200 && k < 5; c++) begin
      tick();
      if (gnt != 4'd0) begin
        chk("t2_gnt_oh", 32'(gnt), 32'(4'b0001 << (g % 4)));
        g++;
      end
      if (new_in) begin
        chk("t2_data", 32'(datain_ext), 32'(exp_b[k]));
        if (k > 0) chk("t2_spacing", 32'(c - last_c), 32'(F + 2));
        last_c = c;
        k++;
      end
    end
    chk("t2_pulses", 32'(k), 32'd5);
    req = 4'b0000;
    wait_idle("t2_idle");

    // rotation past the last grant
    req = 4'b0100;
    tick();
    chk("t3_gnt2", 32'(gnt), 32'b0100);
    chk("t3_last2", 32'(last_grant), 32'd2);
    req = 4'b1001;
    wait_gnt("t3_wait3");
    chk("t3_gnt3", 32'(gnt), 32'b1000);
    chk("t3_last3", 32'(last_grant), 32'd3);
    req = 4'b0001;
    wait_gnt("t3_wait0");
    chk("t3_gnt0", 32'(gnt), 32'b0001);
    chk("t3_last0", 32'(last_grant), 32'd0);
    req = 4'b0000;
    wait_idle("t3_idle");

    // reset three cycles into WAIT
    req = 4'b0010;
    tick();
    chk("t5_gnt", 32'(gnt), 32'b0010);
    tick();
    chk("t5_new_in", 32'(new_in), 32'd1);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t5_rst_gnt", 32'(gnt), 32'd0);
    chk("t5_rst_new_in", 32'(new_in), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_last", 32'(last_grant), 32'd3);
    rst = 1'b0;
    tick();
    chk("t5_regnt", 32'(gnt), 32'b0010);
    req = 4'b0000;

    // request pulsed and dropped inside WAIT
    tick();
    chk("t6_new_in", 32'(new_in), 32'd1);
    tick();
    tick();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    ng = 0;
    np = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (gnt != 4'd0) ng++;
      if (new_in) np++;
    end
    chk("t6_no_gnt", 32'(ng), 32'd0);
    chk("t6_no_new_in", 32'(np), 32'd0);
    chk("t6_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
